// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serves NCH byte sources into one UART tx FIFO.
// Sources are queued on change or force, coalesced while blocked, and spaced by a write gap.
module uart_tx_arbiter #(
  parameter int NCH           = 4,
  parameter int DATA_W        = 8,
  parameter int GAP_CYC       = 2,
  parameter int KEEPALIVE_CYC = 65000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*DATA_W-1:0]   ch_data,
  input  logic [NCH-1:0]          ch_force,
  input  logic                    tx_full,
  output logic [DATA_W-1:0]       w_data,
  output logic                    wr_uart,
  output logic [NCH-1:0]          ch_sent,
  output logic                    busy,
  output logic                    dbg_state
);

  localparam int PTR_W = $clog2(NCH);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int KA_W  = (KEEPALIVE_CYC > 0) ? $clog2(KEEPALIVE_CYC + 1) : 1;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
  localparam logic [KA_W-1:0]  KA_MAX   = KA_W'(KEEPALIVE_CYC);
  localparam logic [KA_W-1:0]  KA_FIRE  = KA_W'((KEEPALIVE_CYC > 0) ? KEEPALIVE_CYC - 1 : 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_e;

  state_e                  state_q,     state_d;
  logic [NCH-1:0]          pending_q,   pending_d;
  logic [NCH*DATA_W-1:0]   last_sent_q, last_sent_d;
  logic [PTR_W-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [GAP_W-1:0]        gap_cnt_q,   gap_cnt_d;
  logic [KA_W-1:0]         ka_cnt_q,    ka_cnt_d;
  logic [DATA_W-1:0]       w_data_q,    w_data_d;
  logic                    wr_uart_q,   wr_uart_d;
  logic [NCH-1:0]          ch_sent_q,   ch_sent_d;

  logic [NCH-1:0]          set_vec;
  logic                    ka_fire;
  logic                    grant_found;
  logic                    grant;
  int                      grant_idx;
  int                      idx;

  always_comb begin
    set_vec     = '0;
    ka_fire     = 1'b0;
    grant_found = 1'b0;
    grant_idx   = 0;
    idx         = 0;

    // A channel is queued when its byte differs from what was last sent, or on a force.
    for (int i = 0; i < NCH; i++) begin
      set_vec[i] = ch_force[i] |
                   (ch_data[i*DATA_W +: DATA_W] != last_sent_q[i*DATA_W +: DATA_W]);
    end
    if (KEEPALIVE_CYC > 0) begin
      ka_fire = (ka_cnt_q == KA_FIRE);
    end
    set_vec[0] = set_vec[0] | ka_fire;

    // First pending channel at or after rr_ptr, wrapping modulo NCH.
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end

    grant = (state_q == S_IDLE) && !tx_full && grant_found;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | set_vec;
    last_sent_d = last_sent_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    ka_cnt_d    = ka_cnt_q;
    w_data_d    = w_data_q;
    wr_uart_d   = 1'b0;
    ch_sent_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          wr_uart_d            = 1'b1;
          w_data_d             = ch_data[grant_idx*DATA_W +: DATA_W];
          ch_sent_d[grant_idx] = 1'b1;
          last_sent_d[grant_idx*DATA_W +: DATA_W] = ch_data[grant_idx*DATA_W +: DATA_W];
          // The byte just latched equals the current input, so only a force or
          // keepalive can re-arm the granted channel in the same cycle.
          pending_d[grant_idx] = ch_force[grant_idx] | ((grant_idx == 0) & ka_fire);
          rr_ptr_d = (grant_idx == NCH - 1) ? '0 : PTR_W'(grant_idx + 1);
          if (GAP_CYC > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (grant) begin
      ka_cnt_d = '0;
    end else if (ka_cnt_q != KA_MAX) begin
      ka_cnt_d = ka_cnt_q + KA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      last_sent_q <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      ka_cnt_q    <= '0;
      w_data_q    <= '0;
      wr_uart_q   <= 1'b0;
      ch_sent_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      last_sent_q <= last_sent_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      ka_cnt_q    <= ka_cnt_d;
      w_data_q    <= w_data_d;
      wr_uart_q   <= wr_uart_d;
      ch_sent_q   <= ch_sent_d;
    end
  end

  assign w_data    = w_data_q;
  assign wr_uart   = wr_uart_q;
  assign ch_sent   = ch_sent_q;
  assign busy      = (|pending_q) | (state_q == S_GAP);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected writes (cycle, channel, byte) are queued
// by the stimulus and popped by monitors whenever a write strobe appears.
module tb_uart_tx_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              rst_ka;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_force;
  logic              tx_full;

  logic [DW-1:0]     w_data;
  logic              wr_uart;
  logic [NCH-1:0]    ch_sent;
  logic              busy;
  logic              dbg_state;

  logic [DW-1:0]     ka_w_data;
  logic              ka_wr_uart;
  logic [NCH-1:0]    ka_ch_sent;
  logic              ka_busy;
  logic              ka_dbg_state;

  localparam logic [NCH*DW-1:0] ZERO_DATA  = '0;
  localparam logic [NCH-1:0]    ZERO_FORCE = '0;

  uart_tx_arbiter #(.NCH(NCH), .DATA_W(DW), .GAP_CYC(2), .KEEPALIVE_CYC(0)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_force(ch_force), .tx_full(tx_full),
    .w_data(w_data), .wr_uart(wr_uart), .ch_sent(ch_sent), .busy(busy),
    .dbg_state(dbg_state)
  );

  uart_tx_arbiter #(.NCH(NCH), .DATA_W(DW), .GAP_CYC(2), .KEEPALIVE_CYC(100)) dut_ka (
    .clk(clk), .rst(rst_ka), .ch_data(ZERO_DATA), .ch_force(ZERO_FORCE), .tx_full(1'b0),
    .w_data(ka_w_data), .wr_uart(ka_wr_uart), .ch_sent(ka_ch_sent), .busy(ka_busy),
    .dbg_state(ka_dbg_state)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {cycle[31:0], ch_sent[3:0], w_data[7:0]}
  logic [43:0] exp_q[$];
  logic [43:0] exp_ka_q[$];
  logic [43:0] mon_e;
  logic [43:0] mon_ka_e;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] v);
    ch_data[i*DW +: DW] = v;
  endtask

  task automatic expect_wr(input int ch, input logic [DW-1:0] d, input int unsigned at);
    logic [3:0] s;
    s = 4'b0001 << ch;
    exp_q.push_back({at, s, d});
  endtask

  // monitors
  always @(negedge clk) begin
    if (wr_uart) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got ch_sent=%b w_data=%h at cycle %0d, required no write",
                 ch_sent, w_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", cyc, mon_e[43:12]);
        check("ch_sent", 32'(ch_sent), 32'(mon_e[11:8]));
        check("w_data", 32'(w_data), 32'(mon_e[7:0]));
      end
    end else begin
      check("idle_ch_sent", 32'(ch_sent), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ka_wr_uart) begin
      if (exp_ka_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ka_unexpected_write: got ch_sent=%b at cycle %0d, required no write",
                 ka_ch_sent, cyc);
      end else begin
        mon_ka_e = exp_ka_q.pop_front();
        check("ka_cycle", cyc, mon_ka_e[43:12]);
        check("ka_ch_sent", 32'(ka_ch_sent), 32'(mon_ka_e[11:8]));
        check("ka_w_data", 32'(ka_w_data), 32'(mon_ka_e[7:0]));
      end
    end
  end

  int unsigned k;
  int unsigned r0;

  initial begin
    rst      = 1'b1;
    rst_ka   = 1'b1;
    ch_data  = '0;
    ch_force = '0;
    tx_full  = 1'b0;
    tick(3);
    check("rst_wr_uart", 32'(wr_uart), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_ch_sent", 32'(ch_sent), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst    = 1'b0;
    rst_ka = 1'b0;
    r0 = cyc;
    for (int n = 1; n <= 4; n++) begin
      exp_ka_q.push_back({r0 + 32'(101 * n), 4'b0001, 8'h00});
    end

    // single change: write two cycles later, nothing more while stable
    tick(2);
    set_ch(2, 8'h35); k = cyc;
    expect_wr(2, 8'h35, k + 2);
    tick(10);
    check("busy_after_t1", 32'(busy), 32'd0);

    // move rr_ptr to 0 via a ch3 write
    set_ch(3, 8'hA0); k = cyc;
    expect_wr(3, 8'hA0, k + 2);
    tick(8);

    // simultaneous changes served in round-robin order, 3 cycles apart
    set_ch(0, 8'h01); set_ch(1, 8'h02); set_ch(3, 8'h03); k = cyc;
    expect_wr(0, 8'h01, k + 2);
    expect_wr(1, 8'h02, k + 5);
    expect_wr(3, 8'h03, k + 8);
    tick(12);

    // rr_ptr back at 0: ch1 before ch3
    set_ch(1, 8'h12); set_ch(3, 8'h13); k = cyc;
    expect_wr(1, 8'h12, k + 2);
    expect_wr(3, 8'h13, k + 5);
    tick(10);

    // coalescing while tx_full
    tx_full = 1'b1;
    set_ch(1, 8'h11); tick(1);
    set_ch(1, 8'h21); tick(1);
    set_ch(1, 8'h41); tick(1);
    check("busy_blocked", 32'(busy), 32'd1);
    tick(4);
    tx_full = 1'b0; k = cyc;
    expect_wr(1, 8'h41, k + 1);
    tick(8);

    // data returns to last_sent before grant: still sent once
    tx_full = 1'b1;
    set_ch(1, 8'h55); tick(1);
    set_ch(1, 8'h41); tick(3);
    tx_full = 1'b0; k = cyc;
    expect_wr(1, 8'h41, k + 1);
    tick(8);

    // single force pulse with unchanged data
    ch_force[3] = 1'b1; k = cyc;
    tick(1);
    ch_force[3] = 1'b0;
    expect_wr(3, 8'h13, k + 2);
    tick(10);

    // force also present in the grant cycle: second write after the gap
    ch_force[3] = 1'b1; k = cyc;
    tick(2);
    ch_force[3] = 1'b0;
    expect_wr(3, 8'h13, k + 2);
    expect_wr(3, 8'h13, k + 5);
    tick(10);

    // byte sampled in the grant cycle; change during gap re-queues
    set_ch(2, 8'h50); k = cyc;
    tick(1);
    set_ch(2, 8'h51);
    tick(1);
    set_ch(2, 8'h52);
    expect_wr(2, 8'h51, k + 2);
    expect_wr(2, 8'h52, k + 5);
    tick(10);

    // reset in the gap with ch2 pending
    set_ch(0, 8'h77); set_ch(2, 8'h78); k = cyc;
    expect_wr(0, 8'h77, k + 2);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_wr_uart", 32'(wr_uart), 32'd0);
    check("midrst_w_data", 32'(w_data), 32'd0);
    check("midrst_ch_sent", 32'(ch_sent), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0; k = cyc;
    expect_wr(0, 8'h77, k + 2);
    expect_wr(1, 8'h41, k + 5);
    expect_wr(2, 8'h78, k + 8);
    expect_wr(3, 8'h13, k + 11);
    tick(15);
    check("busy_end", 32'(busy), 32'd0);

    // idle stretch also shows the KEEPALIVE_CYC=0 instance never writes
    while (cyc < r0 + 420) tick(1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_ka_q_drained", 32'(exp_ka_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
